// File: rtl/iob_bus_split.sv
// Single-master to N-slave bus splitter: decodes address MSBs (with boot remap of
// slave 0 to the last slave) and forwards one request at a time. Optional macro: BUS_TIMEOUT_EN.
module iob_bus_split #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned N_SLAVES  = 2,
  parameter int unsigned P_SLAVES  = 1,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           boot,
  input  logic                           m_valid,
  input  logic [ADDR_W-1:0]              m_addr,
  input  logic [DATA_W-1:0]              m_wdata,
  input  logic [DATA_W/8-1:0]            m_wstrb,
  output logic [DATA_W-1:0]              m_rdata,
  output logic                           m_ready,
  output logic                           err,
  output logic [N_SLAVES-1:0]            s_valid,
  output logic [N_SLAVES*ADDR_W-1:0]     s_addr,
  output logic [N_SLAVES*DATA_W-1:0]     s_wdata,
  output logic [N_SLAVES*DATA_W/8-1:0]   s_wstrb,
  input  logic [N_SLAVES*DATA_W-1:0]     s_rdata,
  input  logic [N_SLAVES-1:0]            s_ready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [P_SLAVES-1:0] LAST = P_SLAVES'(N_SLAVES - 1);

  if (N_SLAVES < 2 || N_SLAVES > 2**P_SLAVES || DATA_W % 8 != 0 || TIMEOUT_W < 1) begin : g_param_err
    $error("iob_bus_split: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [STRB_W-1:0]   wstrb_r;
  logic [P_SLAVES-1:0] tgt, tgt_nxt, sel;
  logic                tgt_bad;
  logic                sel_ready;
  logic [DATA_W-1:0]   sel_rdata;
  logic [DATA_W-1:0]   rdata_r;
  logic                err_r;
  logic                timeout;

  // Target decode in IDLE; boot is only looked at here, so later changes cannot retarget.
  always_comb begin
    sel     = m_addr[ADDR_W-1 -: P_SLAVES];
    tgt_nxt = (boot && sel == '0) ? LAST : sel;
    tgt_bad = {1'b0, tgt_nxt} >= (P_SLAVES+1)'(N_SLAVES);
  end

  // Slave-side mux: only the latched target's ready/rdata are observed.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    s_valid   = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (tgt == P_SLAVES'(i)) begin
        sel_ready  = s_ready[i];
        sel_rdata  = s_rdata[i*DATA_W +: DATA_W];
        s_valid[i] = (state == REQ);
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tcnt;
  logic [TIMEOUT_W-1:0] tcnt_inc;

  assign tcnt_inc = tcnt + 1'b1;
  assign timeout  = &tcnt_inc;

  // Held at zero while idle, so every REQ entry starts from a cleared count.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) tcnt <= '0;
    else if (state == REQ && !sel_ready) tcnt <= tcnt_inc;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (m_valid) state_nxt = tgt_bad ? RESP : REQ;
      REQ:     if (sel_ready || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= '0;
      wdata_r <= '0;
      wstrb_r <= '0;
      tgt     <= '0;
      rdata_r <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (m_valid) begin
          addr_r  <= m_addr;
          wdata_r <= m_wdata;
          wstrb_r <= m_wstrb;
          tgt     <= tgt_nxt;
          rdata_r <= '0;
          err_r   <= tgt_bad;
        end
        REQ: if (sel_ready) begin
          rdata_r <= sel_rdata;
          err_r   <= 1'b0;
        end else if (timeout) begin
          rdata_r <= '0;
          err_r   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign m_ready = (state == RESP);
  assign m_rdata = rdata_r;
  assign err     = err_r;
  assign s_addr  = {N_SLAVES{addr_r}};
  assign s_wdata = {N_SLAVES{wdata_r}};
  assign s_wstrb = {N_SLAVES{wstrb_r}};

endmodule

// File: tb/tb_iob_bus_split.sv
// Scoreboard bench for iob_bus_split: directed requests push expected responses,
// monitors pop and compare on every m_ready.
module tb_iob_bus_split;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, boot, m_valid, m_ready, err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  s_valid, s_ready;
  logic [63:0] s_addr, s_wdata, s_rdata;
  logic [7:0]  s_wstrb;

  logic        d2_boot, d2_valid, d2_ready, d2_err;
  logic [31:0] d2_addr, d2_rdata;
  logic [2:0]  d2_s_valid, d2_s_ready;
  logic [95:0] d2_s_addr, d2_s_wdata, d2_s_rdata;
  logic [11:0] d2_s_wstrb;

  iob_bus_split #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(2), .P_SLAVES(1), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst), .boot(boot), .m_valid(m_valid), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready),
    .err(err), .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready)
  );

  iob_bus_split #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(3), .P_SLAVES(2), .TIMEOUT_W(4)) dut2 (
    .clk(clk), .rst(rst), .boot(d2_boot), .m_valid(d2_valid), .m_addr(d2_addr),
    .m_wdata(32'h0), .m_wstrb(4'h0), .m_rdata(d2_rdata), .m_ready(d2_ready),
    .err(d2_err), .s_valid(d2_s_valid), .s_addr(d2_s_addr), .s_wdata(d2_s_wdata),
    .s_wstrb(d2_s_wstrb), .s_rdata(d2_s_rdata), .s_ready(d2_s_ready)
  );

  int checks = 0;
  int failures = 0;
  logic [32:0] q1[$];
  logic [32:0] q2[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial forever begin
    logic [32:0] e;
    @(negedge clk);
    if (m_ready) begin
      if (q1.size() == 0) chk("m1_unexpected_ready", 1, 0);
      else begin
        e = q1.pop_front();
        chk("m1_rdata", m_rdata, e[32:1]);
        chk("m1_err", err, e[0]);
      end
    end
  end

  initial forever begin
    logic [32:0] e;
    @(negedge clk);
    if (d2_ready) begin
      if (q2.size() == 0) chk("m2_unexpected_ready", 1, 0);
      else begin
        e = q2.pop_front();
        chk("m2_rdata", d2_rdata, e[32:1]);
        chk("m2_err", d2_err, e[0]);
      end
    end
  end

  // One request on dut: target waits 'delay' cycles (other slave's ready held high) then responds.
  task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     input logic b, input int delay, input logic [31:0] rd, input logic [1:0] exp_sv);
    @(negedge clk);
    m_valid = 1'b1; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb; boot = b;
    q1.push_back({rd, 1'b0});
    @(negedge clk);
    chk("s_valid_onehot", s_valid, exp_sv);
    chk("s_addr_all", s_addr, {addr, addr});
    chk("s_wdata_all", s_wdata, {wdata, wdata});
    chk("s_wstrb_all", s_wstrb, {wstrb, wstrb});
    boot = ~b;
    s_rdata = exp_sv[1] ? {rd, ~rd} : {~rd, rd};
    for (int i = 0; i < delay; i++) begin
      s_ready = ~exp_sv;
      @(negedge clk);
      chk("s_valid_hold", s_valid, exp_sv);
    end
    s_ready = exp_sv;
    @(negedge clk);
    chk("m_ready_latency", m_ready, 1);
    chk("s_valid_drop", s_valid, 0);
    m_valid = 1'b0; s_ready = '0;
    @(negedge clk);
    chk("m_ready_pulse", m_ready, 0);
  endtask

  initial begin
    rst = 1'b1; boot = 0; m_valid = 0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_rdata = '0; s_ready = '0;
    d2_boot = 0; d2_valid = 0; d2_addr = '0; d2_s_rdata = '0; d2_s_ready = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_ready", m_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_m_rdata", m_rdata, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_s_addr", s_addr, 0);
    rst = 1'b0;

    txn(32'h8000_0010, 32'h0, 4'h0, 1'b0, 2, 32'hDEAD_BEEF, 2'b10);
    txn(32'h0000_0004, 32'h0, 4'h0, 1'b1, 0, 32'h1234_5678, 2'b10);
    txn(32'h0000_0004, 32'h0, 4'h0, 1'b0, 1, 32'hCAFE_F00D, 2'b01);
    txn(32'h0000_0008, 32'hA5A5_5A5A, 4'hF, 1'b0, 0, 32'h1111_2222, 2'b01);
    txn(32'h0000_000C, 32'h0, 4'h0, 1'b0, 0, 32'h3333_4444, 2'b01);

    // Reset while in REQ: transaction abandoned, no response.
    @(negedge clk);
    m_valid = 1'b1; m_addr = 32'h0; m_wstrb = 4'h0; boot = 0;
    @(negedge clk);
    chk("pre_rst_s_valid", s_valid, 2'b01);
    rst = 1'b1; m_valid = 1'b0;
    @(negedge clk);
    chk("rst_req_s_valid", s_valid, 0);
    chk("rst_req_m_ready", m_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_m_ready", m_ready, 0);
    txn(32'h8000_0000, 32'h0, 4'h0, 1'b0, 0, 32'h5555_AAAA, 2'b10);

    // Three-slave instance: decode error, then boot remap to slave 2.
    @(negedge clk);
    d2_valid = 1'b1; d2_addr = 32'hC000_0000; d2_boot = 0;
    q2.push_back({32'h0, 1'b1});
    @(negedge clk);
    chk("d2_err_s_valid", d2_s_valid, 0);
    chk("d2_err_m_ready", d2_ready, 1);
    d2_valid = 1'b0;
    @(negedge clk);
    chk("d2_err_pulse", d2_ready, 0);
    d2_valid = 1'b1; d2_addr = 32'h0000_0100; d2_boot = 1;
    q2.push_back({32'h7777_0002, 1'b0});
    @(negedge clk);
    chk("d2_boot_s_valid", d2_s_valid, 3'b100);
    d2_s_ready = 3'b100; d2_s_rdata = {32'h7777_0002, 32'h1, 32'h0};
    @(negedge clk);
    chk("d2_boot_m_ready", d2_ready, 1);
    d2_valid = 1'b0; d2_s_ready = '0;

`ifdef BUS_TIMEOUT_EN
    begin
      int cnt;
      @(negedge clk);
      m_valid = 1'b1; m_addr = 32'h0; m_wstrb = 4'h0; boot = 0;
      q1.push_back({32'h0, 1'b1});
      cnt = 0;
      @(negedge clk);
      while (s_valid[0] && cnt < 100) begin
        cnt++;
        @(negedge clk);
      end
      chk("timeout_req_cycles", cnt, 15);
      chk("timeout_m_ready", m_ready, 1);
      m_valid = 1'b0;
    end
`endif

    repeat (3) @(negedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
